ysyx_201979054_mem_arbiter: RTL and testbench
=============================================

Name: ysyx_201979054_mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the single shared AXI4 master request interface.
- Port 0 is the instruction-side refill path. Port 1 is the data-side path: refill, writeback or non-cacheable byte access.
- Latches the winner's transaction attributes, drives the master's request until done, and routes per-beat handshakes and the completion pulse back to the owner.
- Checks beat count against requested length.

Parameters:
ADDR_WIDTH, 32, address width of requests and master address.
DATA_WIDTH, 64, beat data width.

Ports:
clk  in  1  clock.
arst  in  1  reset: synchronous, active-low; the name is kept for codebase consistency.
i_req0, i_req1  in  1 each  transaction request, level; held until the port's done pulse.
i_we0, i_we1  in  1 each  1 = write, 0 = read.
i_addr0, i_addr1  in  ADDR_WIDTH each  start address.
i_len0, i_len1  in  8 each  AXI len (beats-1).
i_size0, i_size1  in  3 each  AXI size.
i_strb0, i_strb1  in  8 each  write strobe.
i_wdata0, i_wdata1  in  DATA_WIDTH each  current write beat (requester advances on its beat pulse).
o_gnt0, o_gnt1  out  1 each  port owns master (BUSY/DONE).
o_beat0, o_beat1  out  1 each  beat handshake pulse routed to owner.
o_done0, o_done1  out  1 each  one-cycle completion pulse.
o_rdata  out  DATA_WIDTH  read beat data, broadcast.
o_read_req, o_write_req  out  1 each  to master i_read_req / i_write_req.
o_addr  out  ADDR_WIDTH  to master.
o_len  out  8  to master.
o_size  out  3  to master.
o_strb  out  8  to master.
o_wdata  out  DATA_WIDTH  to master.
i_axi_handshake  in  1  master beat handshake (R or W).
i_axi_done  in  1  master transaction complete.
i_rdata  in  DATA_WIDTH  master read data.
o_len_err  out  1  sticky: beat count mismatch seen.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Registers: state, owner (1b), last_gnt (1b), we_q, addr_q, len_q, size_q, strb_q, beat_cnt (9b), len_err.
- Reset (arst=0 at an edge): state=IDLE, owner=0, last_gnt=1 so port 0 wins first, beat_cnt=0, len_err=0, latched attributes 0.
- Combinational outputs are therefore 0 during reset: gnt, beat, done, read_req, write_req, addr, len, size, strb, wdata.
- IDLE, arbitration:
  - Single request: that port wins.
  - Both requesting: the port != last_gnt wins.
  - At the edge: latch the winner's we/addr/len/size/strb, owner=winner, last_gnt=winner, beat_cnt=0, go to BUSY.
  - No request: stay IDLE.
- Latency: request high before edge k → o_gnt and o_read_req/o_write_req high after edge k (1 cycle).
- BUSY:
  - o_read_req=~we_q and o_write_req=we_q, held constant until done.
  - o_addr/len/size/strb come from the latched registers; o_wdata is combinationally muxed from i_wdata[owner].
  - o_beatN = i_axi_handshake & BUSY & owner==N.
  - beat_cnt increments on each i_axi_handshake, saturating at 256.
  - On i_axi_done: go to DONE. If the effective beat count (beat_cnt plus a same-cycle handshake) != len_q+1, set len_err.
- DONE (exactly 1 cycle):
  - o_doneN=1 for owner; o_read_req/o_write_req=0; gnt stays high.
  - Requests are ignored this cycle; the owner must drop i_req by the next edge.
  - Next state IDLE. Arbitration resumes the following cycle, so min turnaround is 1 idle cycle between transactions.
- Other rules:
  - Handshakes or done in IDLE/DONE are ignored, and do not count.
  - The owner dropping i_req in BUSY is illegal; the arbiter keeps driving the latched request.
  - o_rdata = i_rdata always.
  - o_len_err clears only on reset.
  - Reset mid-BUSY: immediate IDLE with all outputs 0 and no done pulse; the master is reset alongside.

Test Plan:
- Port 0 only: read addr 0x8000_0000, len 7, size 3.
  - → o_read_req after 1 cycle; 8 handshakes produce 8 o_beat0 pulses, none on port 1.
  - → done after 8th beat with i_axi_done gives o_done0 one cycle, then IDLE; o_len_err=0.
- Both request in the same cycle right after reset.
  - → port 0 granted first; port 1 granted 1 idle cycle after o_done0.
  - → next simultaneous request grants port 1 first (last_gnt rule).
- Port 1 non-cacheable write: addr 0x1000_0000, len 0, size 0, strb 0x01, wdata 0xAB repeated.
  - → o_write_req=1, o_strb=0x01, o_wdata tracks i_wdata1; one beat then done → o_done1.
- Port 0 read len 7 with done after only 6 handshakes.
  - → o_len_err=1 and stays 1 through later good transactions until arst=0.
- Last handshake coincident with i_axi_done in the same cycle, len 3.
  - → counted as the 4th beat; no len_err.
- arst=0 asserted mid-BUSY after 3 beats.
  - → next cycle all outputs 0, state IDLE, no done pulse; a new port 0 request is granted normally.

Source files
------------

// File: rtl/ysyx_201979054_mem_arbiter_if.sv
// Bundle of requester-side and AXI-master-side signals around the shared memory arbiter.
// Handshake: a requester holds i_reqN with stable attributes until its one-cycle o_doneN;
// every o_beatN pulse is one accepted beat, after which the requester presents its next i_wdataN.
interface ysyx_201979054_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  i_req0;
    logic                  i_req1;
    logic                  i_we0;
    logic                  i_we1;
    logic [ADDR_WIDTH-1:0] i_addr0;
    logic [ADDR_WIDTH-1:0] i_addr1;
    logic [7:0]            i_len0;
    logic [7:0]            i_len1;
    logic [2:0]            i_size0;
    logic [2:0]            i_size1;
    logic [7:0]            i_strb0;
    logic [7:0]            i_strb1;
    logic [DATA_WIDTH-1:0] i_wdata0;
    logic [DATA_WIDTH-1:0] i_wdata1;
    logic                  o_gnt0;
    logic                  o_gnt1;
    logic                  o_beat0;
    logic                  o_beat1;
    logic                  o_done0;
    logic                  o_done1;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_read_req;
    logic                  o_write_req;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [7:0]            o_len;
    logic [2:0]            o_size;
    logic [7:0]            o_strb;
    logic [DATA_WIDTH-1:0] o_wdata;
    logic                  i_axi_handshake;
    logic                  i_axi_done;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  o_len_err;
    logic [1:0]            dbg_state;

    modport slave (
        input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_len0, i_len1,
               i_size0, i_size1, i_strb0, i_strb1, i_wdata0, i_wdata1,
               i_axi_handshake, i_axi_done, i_rdata,
        output o_gnt0, o_gnt1, o_beat0, o_beat1, o_done0, o_done1, o_rdata,
               o_read_req, o_write_req, o_addr, o_len, o_size, o_strb, o_wdata,
               o_len_err, dbg_state
    );

    modport master (
        output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_len0, i_len1,
               i_size0, i_size1, i_strb0, i_strb1, i_wdata0, i_wdata1,
               i_axi_handshake, i_axi_done, i_rdata,
        input  o_gnt0, o_gnt1, o_beat0, o_beat1, o_done0, o_done1, o_rdata,
               o_read_req, o_write_req, o_addr, o_len, o_size, o_strb, o_wdata,
               o_len_err, dbg_state
    );
endinterface

// File: rtl/ysyx_201979054_mem_arbiter.sv
// Round-robin arbiter between the instruction (port 0) and data (port 1) paths for one
// shared AXI4 master; latches the winner's request and routes beats/completion back to it.
module ysyx_201979054_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic clk,
    input  logic arst,
    ysyx_201979054_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  last_gnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [7:0]            strb_q;
    logic [8:0]            beat_cnt;
    logic                  len_err;

    logic                  any_req;
    logic                  winner;
    logic                  busy;
    logic                  owned;
    logic [9:0]            eff_beats;
    logic [8:0]            want_beats;
    logic [DATA_WIDTH-1:0] wdata_sel;

    always_comb begin
        any_req = bus.i_req0 | bus.i_req1;
        // On a tie the port that did not win last time gets the master.
        if (bus.i_req0 && bus.i_req1) begin
            winner = ~last_gnt;
        end else begin
            winner = bus.i_req1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (bus.i_axi_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A handshake arriving together with done still counts as a beat.
    assign eff_beats  = {1'b0, beat_cnt} + {9'd0, bus.i_axi_handshake};
    assign want_beats = {1'b0, len_q} + 9'd1;

    always_ff @(posedge clk) begin
        if (!arst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            strb_q   <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        last_gnt <= winner;
                        we_q     <= winner ? bus.i_we1   : bus.i_we0;
                        addr_q   <= winner ? bus.i_addr1 : bus.i_addr0;
                        len_q    <= winner ? bus.i_len1  : bus.i_len0;
                        size_q   <= winner ? bus.i_size1 : bus.i_size0;
                        strb_q   <= winner ? bus.i_strb1 : bus.i_strb0;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (bus.i_axi_handshake && beat_cnt != 9'd256) begin
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                    if (bus.i_axi_done && eff_beats != {1'b0, want_beats}) begin
                        len_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign owned     = (state == BUSY) || (state == DONE);
    assign wdata_sel = owner ? bus.i_wdata1 : bus.i_wdata0;

    assign bus.o_gnt0      = owned & ~owner;
    assign bus.o_gnt1      = owned & owner;
    assign bus.o_beat0     = bus.i_axi_handshake & busy & ~owner;
    assign bus.o_beat1     = bus.i_axi_handshake & busy & owner;
    assign bus.o_done0     = (state == DONE) & ~owner;
    assign bus.o_done1     = (state == DONE) & owner;
    assign bus.o_read_req  = busy & ~we_q;
    assign bus.o_write_req = busy & we_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_len       = len_q;
    assign bus.o_size      = size_q;
    assign bus.o_strb      = strb_q;
    assign bus.o_wdata     = busy ? wdata_sel : '0;
    assign bus.o_rdata     = bus.i_rdata;
    assign bus.o_len_err   = len_err;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_ysyx_201979054_mem_arbiter.sv
// Bench for the two-port memory arbiter: directed vectors, corner sequences and a
// randomized run, all compared against a transaction-level model of the arbiter.
module tb_ysyx_201979054_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    ysyx_201979054_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_201979054_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [7:0]  strb;
    } attr_t;

    bit    m_active;     // transfer in flight on the master
    bit    m_finishing;  // completion cycle for the owner
    int    m_owner;
    int    m_prev;       // port that won most recently
    int    m_beats;
    bit    m_err;
    attr_t m_attr;

    int cnt_b0, cnt_b1, cnt_d0, cnt_d1;
    logic [AW-1:0] seen_wr_addr;
    logic [7:0]    seen_wr_strb;
    logic [DW-1:0] seen_wr_data;

    function automatic attr_t port_attr(input int p);
        attr_t a;
        if (p == 0) begin
            a.we = bus.i_we0; a.addr = bus.i_addr0; a.len = bus.i_len0;
            a.size = bus.i_size0; a.strb = bus.i_strb0;
        end else begin
            a.we = bus.i_we1; a.addr = bus.i_addr1; a.len = bus.i_len1;
            a.size = bus.i_size1; a.strb = bus.i_strb1;
        end
        return a;
    endfunction

    task automatic model_edge();
        int eff;
        int w;
        if (!arst) begin
            m_active = 0; m_finishing = 0; m_owner = 0; m_prev = 1; m_beats = 0; m_err = 0;
            m_attr = '{we: 1'b0, addr: '0, len: '0, size: '0, strb: '0};
        end else if (m_finishing) begin
            m_finishing = 0;
        end else if (m_active) begin
            eff = m_beats + (bus.i_axi_handshake ? 1 : 0);
            if (bus.i_axi_handshake) m_beats = (eff > 256) ? 256 : eff;
            if (bus.i_axi_done) begin
                if (eff != int'(m_attr.len) + 1) m_err = 1;
                m_active = 0;
                m_finishing = 1;
            end
        end else if (bus.i_req0 || bus.i_req1) begin
            if (bus.i_req0 && bus.i_req1) w = 1 - m_prev;
            else w = bus.i_req1 ? 1 : 0;
            m_attr = port_attr(w);
            m_owner = w;
            m_prev = w;
            m_beats = 0;
            m_active = 1;
        end
    endtask

    task automatic sample();
        bit own;
        logic [DW-1:0] exp_wd;
        @(negedge clk);
        own = m_active || m_finishing;
        exp_wd = m_active ? ((m_owner == 1) ? bus.i_wdata1 : bus.i_wdata0) : '0;
        chk("gnt0", bus.o_gnt0, own && m_owner == 0);
        chk("gnt1", bus.o_gnt1, own && m_owner == 1);
        chk("beat0", bus.o_beat0, m_active && bus.i_axi_handshake && m_owner == 0);
        chk("beat1", bus.o_beat1, m_active && bus.i_axi_handshake && m_owner == 1);
        chk("done0", bus.o_done0, m_finishing && m_owner == 0);
        chk("done1", bus.o_done1, m_finishing && m_owner == 1);
        chk("read_req", bus.o_read_req, m_active && !m_attr.we);
        chk("write_req", bus.o_write_req, m_active && m_attr.we);
        chk("addr", bus.o_addr, m_attr.addr);
        chk("len", bus.o_len, m_attr.len);
        chk("size", bus.o_size, m_attr.size);
        chk("strb", bus.o_strb, m_attr.strb);
        chk("wdata", bus.o_wdata, exp_wd);
        chk("rdata", bus.o_rdata, bus.i_rdata);
        chk("len_err", bus.o_len_err, m_err);
        if (bus.o_beat0) cnt_b0++;
        if (bus.o_beat1) cnt_b1++;
        if (bus.o_done0) cnt_d0++;
        if (bus.o_done1) cnt_d1++;
        if (bus.o_write_req) begin
            seen_wr_addr = bus.o_addr;
            seen_wr_strb = bus.o_strb;
            seen_wr_data = bus.o_wdata;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input bit v);
        if (p == 0) bus.i_req0 = v;
        else bus.i_req1 = v;
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [7:0] strb);
        if (p == 0) begin
            bus.i_we0 = we; bus.i_addr0 = addr; bus.i_len0 = len;
            bus.i_size0 = size; bus.i_strb0 = strb;
        end else begin
            bus.i_we1 = we; bus.i_addr1 = addr; bus.i_len1 = len;
            bus.i_size1 = size; bus.i_strb1 = strb;
        end
    endtask

    task automatic clear_counts();
        cnt_b0 = 0; cnt_b1 = 0; cnt_d0 = 0; cnt_d1 = 0;
    endtask

    task automatic wait_grant(input int p);
        int guard;
        guard = 0;
        while (!(m_active && m_owner == p) && guard < 8) begin
            step();
            guard++;
        end
        chk("grant_timeout", guard >= 8, 1'b0);
    endtask

    task automatic run_txn(input int p, input bit we, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [7:0] strb,
                           input int nhs, input bit coincide);
        clear_counts();
        set_port(p, we, addr, len, size, strb);
        set_req(p, 1'b1);
        bus.i_axi_handshake = 0;
        bus.i_axi_done = 0;
        wait_grant(p);
        for (int i = 0; i < nhs; i++) begin
            bus.i_axi_handshake = 1;
            bus.i_axi_done = coincide && (i == nhs - 1);
            step();
        end
        if (!coincide) begin
            bus.i_axi_handshake = 0;
            bus.i_axi_done = 1;
            step();
        end
        bus.i_axi_handshake = 0;
        bus.i_axi_done = 0;
        set_req(p, 1'b0);
        step();
        step();
    endtask

    task automatic drive_random();
        int tgt;
        for (int p = 0; p < 2; p++) begin
            if (m_finishing && m_owner == p) begin
                set_req(p, 1'b0);
            end else if (((p == 0) ? bus.i_req0 : bus.i_req1) == 1'b0 && $urandom_range(0, 3) == 0) begin
                set_port(p, 1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 5)),
                         3'($urandom_range(0, 3)), 8'($urandom));
                set_req(p, 1'b1);
            end
        end
        bus.i_wdata0 = {$urandom, $urandom};
        bus.i_wdata1 = {$urandom, $urandom};
        bus.i_rdata  = {$urandom, $urandom};
        if (m_active) begin
            tgt = int'(m_attr.len) + 1;
            if (m_beats >= tgt) begin
                bus.i_axi_handshake = 0;
                bus.i_axi_done = 1;
            end else begin
                bus.i_axi_handshake = 1'($urandom_range(0, 1));
                bus.i_axi_done = (m_beats + int'(bus.i_axi_handshake) == tgt) && ($urandom_range(0, 1) == 1);
            end
        end else begin
            bus.i_axi_handshake = ($urandom_range(0, 7) == 0);
            bus.i_axi_done = ($urandom_range(0, 7) == 0);
        end
    endtask

    // ---------------- directed vector table ----------------
    // exp = {gnt0, gnt1, read_req, write_req, beat0, beat1, done0, done1}
    typedef struct {
        bit         req0;
        bit         req1;
        bit         hs;
        bit         dn;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input bit r0, input bit r1, input bit hs, input bit dn, input logic [7:0] e);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.hs = hs; v.dn = dn; v.exp = e;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 8'b0000_0000);
        tbl[1]  = mk(1, 1, 1, 1, 8'b1010_1000);
        tbl[2]  = mk(0, 1, 0, 0, 8'b1000_0010);
        tbl[3]  = mk(0, 1, 0, 0, 8'b0000_0000);
        tbl[4]  = mk(0, 1, 1, 1, 8'b0101_0100);
        tbl[5]  = mk(0, 0, 0, 0, 8'b0100_0001);
        tbl[6]  = mk(1, 0, 0, 0, 8'b0000_0000);
        tbl[7]  = mk(1, 0, 1, 1, 8'b1010_1000);
        tbl[8]  = mk(0, 0, 0, 0, 8'b1000_0010);
        tbl[9]  = mk(1, 1, 0, 0, 8'b0000_0000);
        tbl[10] = mk(1, 1, 0, 0, 8'b0101_0000);
        tbl[11] = mk(1, 1, 1, 1, 8'b0101_0100);
        tbl[12] = mk(1, 0, 0, 0, 8'b0100_0001);
        tbl[13] = mk(1, 0, 0, 0, 8'b0000_0000);
        tbl[14] = mk(1, 0, 1, 1, 8'b1010_1000);
        tbl[15] = mk(0, 0, 0, 0, 8'b1000_0010);
        tbl[16] = mk(0, 0, 0, 0, 8'b0000_0000);

        // Reset with busy-looking inputs that must all be ignored.
        arst = 1'b0;
        bus.i_req0 = 1; bus.i_req1 = 1;
        set_port(0, 1'b1, 32'h1234_5678, 8'd3, 3'd3, 8'hff);
        set_port(1, 1'b1, 32'h9abc_def0, 8'd1, 3'd2, 8'h0f);
        bus.i_wdata0 = 64'hdead_beef_0000_0001;
        bus.i_wdata1 = 64'hdead_beef_0000_0002;
        bus.i_rdata  = 64'h0123_4567_89ab_cdef;
        bus.i_axi_handshake = 1;
        bus.i_axi_done = 1;
        advance();
        advance();
        sample();
        chk("reset_outs", {bus.o_gnt0, bus.o_gnt1, bus.o_read_req, bus.o_write_req,
                           bus.o_beat0, bus.o_beat1, bus.o_done0, bus.o_done1}, 8'h00);
        chk("reset_wdata", bus.o_wdata, 64'h0);
        chk("reset_addr", bus.o_addr, 32'h0);
        chk("reset_len_err", bus.o_len_err, 1'b0);
        advance();

        // Tie right after reset: port 0 first, then alternation by last grant.
        arst = 1'b1;
        set_port(0, 1'b0, 32'h8000_0100, 8'd0, 3'd3, 8'hff);
        set_port(1, 1'b1, 32'h1000_0100, 8'd0, 3'd3, 8'hff);
        for (int i = 0; i < 17; i++) begin
            bus.i_req0 = tbl[i].req0;
            bus.i_req1 = tbl[i].req1;
            bus.i_axi_handshake = tbl[i].hs;
            bus.i_axi_done = tbl[i].dn;
            sample();
            chk($sformatf("tbl_row%0d", i),
                {bus.o_gnt0, bus.o_gnt1, bus.o_read_req, bus.o_write_req,
                 bus.o_beat0, bus.o_beat1, bus.o_done0, bus.o_done1}, tbl[i].exp);
            chk($sformatf("tbl_err%0d", i), bus.o_len_err, 1'b0);
            advance();
        end

        // Port 0 8-beat read.
        run_txn(0, 1'b0, 32'h8000_0000, 8'd7, 3'd3, 8'hff, 8, 1'b0);
        chk("p0_read_beats0", cnt_b0, 8);
        chk("p0_read_beats1", cnt_b1, 0);
        chk("p0_read_done0", cnt_d0, 1);
        chk("p0_read_len_err", bus.o_len_err, 1'b0);

        // Port 1 single-byte non-cacheable write.
        bus.i_wdata1 = {8{8'hAB}};
        seen_wr_addr = '0; seen_wr_strb = '0; seen_wr_data = '0;
        run_txn(1, 1'b1, 32'h1000_0000, 8'd0, 3'd0, 8'h01, 1, 1'b0);
        chk("p1_wr_addr", seen_wr_addr, 32'h1000_0000);
        chk("p1_wr_strb", seen_wr_strb, 8'h01);
        chk("p1_wr_data", seen_wr_data, {8{8'hAB}});
        chk("p1_wr_beats", cnt_b1, 1);
        chk("p1_wr_done1", cnt_d1, 1);
        chk("p1_wr_done0", cnt_d0, 0);

        // Last handshake coincident with done still counts.
        run_txn(0, 1'b0, 32'h8000_1000, 8'd3, 3'd3, 8'hff, 4, 1'b1);
        chk("coincide_beats", cnt_b0, 4);
        chk("coincide_len_err", bus.o_len_err, 1'b0);

        // Short burst sets the sticky error, which survives a good transfer.
        run_txn(0, 1'b0, 32'h8000_2000, 8'd7, 3'd3, 8'hff, 6, 1'b0);
        chk("short_len_err", bus.o_len_err, 1'b1);
        run_txn(1, 1'b0, 32'h8000_4000, 8'd1, 3'd3, 8'hff, 2, 1'b0);
        chk("sticky_len_err", bus.o_len_err, 1'b1);

        // Reset in the middle of a burst.
        clear_counts();
        set_port(0, 1'b0, 32'h8000_5000, 8'd7, 3'd3, 8'hff);
        set_req(0, 1'b1);
        bus.i_axi_handshake = 0;
        bus.i_axi_done = 0;
        wait_grant(0);
        for (int i = 0; i < 3; i++) begin
            bus.i_axi_handshake = 1;
            step();
        end
        bus.i_axi_handshake = 0;
        set_req(0, 1'b0);
        arst = 1'b0;
        step();
        arst = 1'b1;
        sample();
        chk("midrst_outs", {bus.o_gnt0, bus.o_gnt1, bus.o_read_req, bus.o_write_req,
                            bus.o_beat0, bus.o_beat1, bus.o_done0, bus.o_done1}, 8'h00);
        chk("midrst_addr", bus.o_addr, 32'h0);
        chk("midrst_len_err", bus.o_len_err, 1'b0);
        advance();
        step();
        chk("midrst_no_done", cnt_d0, 0);
        chk("midrst_beats", cnt_b0, 3);
        run_txn(0, 1'b0, 32'h8000_6000, 8'd1, 3'd3, 8'hff, 2, 1'b0);
        chk("post_rst_done0", cnt_d0, 1);
        chk("post_rst_len_err", bus.o_len_err, 1'b0);

        // Randomized traffic from both ports.
        bus.i_req0 = 0;
        bus.i_req1 = 0;
        for (int c = 0; c < 1500; c++) begin
            drive_random();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
